div_16x8_seq: RTL and testbench
===============================

// Module: div_16x8_seq
// PURPOSE
//   Sequential restoring divider: R-style 16-bit dividend A over 8-bit divisor B -> 16-bit quotient, 8-bit remainder.
//   Inverse datapath of the 8x8 product units; recovers operands/ratios from 16-bit products in the same
//   approximate-arithmetic library. Optional approximation skips the low quotient iterations for lower latency.
//   One iteration per clock; start/done handshake toward the surrounding accelerator datapath.
// PARAMETERS
//   APPROX_BITS  0   number of quotient LSBs not computed (0..8); those iterations are skipped
//   AW           16  dividend width (fixed; documents package constant)
//   BW           8   divisor width (fixed; documents package constant)
// PORTS
//   clk    in   1   single clock, rising edge
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   request; sampled only when busy=0
//   A      in   16  dividend, captured on accepted start
//   B      in   8   divisor, captured on accepted start
//   busy   out  1   high from cycle after accepted start until done cycle (inclusive of iterations, not done)
//   done   out  1   one-cycle pulse: Q/Rem/DZ valid from this cycle until next accepted start
//   Q      out  16  quotient
//   Rem    out  8   remainder
//   DZ     out  1   divide-by-zero flag for the last operation
// BEHAVIOUR
//   - Reset (async assert): state=IDLE; busy=0, done=0, Q=0, Rem=0, DZ=0; internal regs cleared.
//   - States: IDLE -> (start & B!=0) -> RUN -> (iter==APPROX_BITS) -> DONE -> IDLE;
//             IDLE -> (start & B==0) -> DONE (DZ path).
//   - Accept: start=1 while IDLE captures A,B; start while RUN/DONE is ignored (no queueing).
//   - Iteration i = 15 down to APPROX_BITS, one per cycle: p = {rem[7:0], A[i]} (9 bits);
//       if p >= {1'b0,B}: rem <= p - B, Q[i] <= 1; else rem <= p[7:0], Q[i] <= 0.
//   - Q[APPROX_BITS-1:0] forced 0. Result: Q = ((A>>k)/B)<<k, Rem = (A>>k) mod B, k=APPROX_BITS.
//     k=0 gives the exact result.
//   - Latency: done asserted exactly 17-k cycles after the accepting start cycle; next start accepted in
//     the cycle after done (back-to-back issue rate 18-k cycles).
//   - Divide by zero: no iterations; done 1 cycle after start; Q=16'hFFFF, Rem=A[7:0], DZ=1.
//     DZ cleared on next accepted start with B!=0.
//   - Q/Rem/DZ update only in the done cycle; stable otherwise (intermediate values held internally).
//   - Reset mid-operation: operation abandoned, no done pulse, outputs return to reset values.
//   - start asserted in the done cycle: ignored (state is DONE, not IDLE).
//   - Widths: remainder compare/subtract on 9 bits; no overflow possible since rem < B always holds.
// STRUCTURE
//   - Shared package div_pkg: state encoding (IDLE, RUN, DONE), AW=16, BW=8, DZ quotient constant 16'hFFFF.
//   - Sub-module div_step: combinational restoring step ({rem, bit}, B) -> (rem_next, q_bit);
//     instantiated once, iterated by a 4-bit counter in the FSM.
//   - Top: FSM, iteration counter, A shift/index, Q shift register, Rem register, output registers.
// TESTING
//   - k=0: A=1000, B=7, start 1 cycle -> done 17 cycles later, Q=142, Rem=6, DZ=0, busy high in between.
//   - k=0: A=65535, B=1 -> Q=65535, Rem=0; A=255, B=255 -> Q=1, Rem=0; A=5, B=200 -> Q=0, Rem=5.
//   - B=0, A=16'h12AB -> done 1 cycle later, Q=16'hFFFF, Rem=8'hAB, DZ=1; next op A=10,B=3 -> DZ=0, Q=3, Rem=1.
//   - k=4: A=1000, B=7 -> done 13 cycles after start, Q=128, Rem=6.
//   - start pulsed every cycle with changing A/B during RUN -> only first operands used, one done pulse.
//   - rst asserted at iteration 8 of A=1000,B=7 -> outputs 0 immediately, no done; re-issue -> Q=142, Rem=6.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
//============================================================================
// Package     : div_pkg
// Description : Shared definitions for the sequential 16/8 restoring divider:
//               FSM state encoding, operand widths and the quotient value
//               reported on a divide-by-zero.
// Contents    : state_t        - IDLE / RUN / DONE
//               C_AW, C_BW     - dividend / divisor widths
//               C_DZ_QUOT      - quotient returned when the divisor is zero
// Revision    : 1.0 - initial release
//============================================================================
package div_pkg;

   localparam int C_AW = 16;
   localparam int C_BW = 8;

   localparam logic [C_AW-1:0] C_DZ_QUOT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_16x8_seq_if.sv
`default_nettype none
//============================================================================
// Interface   : div_16x8_seq_if
// Description : start/done handshake and operand/result bus of the divider.
// Signals     : start  - request, honoured only while the divider is idle
//               A, B   - dividend / divisor, captured on an accepted start
//               busy   - iterations in progress
//               done   - one-cycle completion pulse
//               Q, Rem - quotient / remainder of the last operation
//               DZ     - last operation divided by zero
// Modports    : master - requester side, slave - divider side
// Revision    : 1.0 - initial release
//============================================================================
interface div_16x8_seq_if;
   import div_pkg::*;

   logic              start;
   logic [C_AW-1:0]   A;
   logic [C_BW-1:0]   B;
   logic              busy;
   logic              done;
   logic [C_AW-1:0]   Q;
   logic [C_BW-1:0]   Rem;
   logic              DZ;

   modport master (
      output start, A, B,
      input  busy, done, Q, Rem, DZ
   );

   modport slave (
      input  start, A, B,
      output busy, done, Q, Rem, DZ
   );

endinterface : div_16x8_seq_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
//============================================================================
// Module      : div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder and subtracts the
//               divisor when it fits.
// Ports       : rem_i  in  8  partial remainder (always < b_i)
//               bit_i  in  1  next dividend bit
//               b_i    in  8  divisor
//               rem_o  out 8  updated partial remainder
//               q_o    out 1  quotient bit produced by this step
// Revision    : 1.0 - initial release
//============================================================================
module div_step
   import div_pkg::*;
(
   input  wire logic [C_BW-1:0] rem_i,
   input  wire logic            bit_i,
   input  wire logic [C_BW-1:0] b_i,
   output logic      [C_BW-1:0] rem_o,
   output logic                 q_o
);

   logic [C_BW:0] w_p;

   always_comb begin
      w_p   = {rem_i, bit_i};
      q_o   = 1'b0;
      rem_o = w_p[C_BW-1:0];
      if (w_p >= {1'b0, b_i}) begin
         q_o   = 1'b1;
         // rem_i < b_i guarantees p - b < b, so the 8-bit difference is exact
         // even though p[8] may have been set.
         rem_o = w_p[C_BW-1:0] - b_i;
      end
   end

endmodule : div_step
`default_nettype wire

// File: rtl/div_16x8_seq.sv
`default_nettype none
//============================================================================
// Module      : div_16x8_seq
// Description : Sequential restoring divider, 16-bit dividend over 8-bit
//               divisor, one quotient bit per clock. The lowest APPROX_BITS
//               quotient bits are not computed (forced to zero) to shorten
//               latency: Q = ((A>>k)/B)<<k, Rem = (A>>k) mod B.
//               Latency from accepting start to done is 17-k cycles; a zero
//               divisor finishes in 1 cycle with Q=FFFF, Rem=A[7:0], DZ=1.
// Ports       : clk  in  1  clock, rising edge
//               rst  in  1  asynchronous active-high reset
//               bus  slave  handshake/operand/result interface
// Revision    : 1.0 - initial release
//============================================================================
module div_16x8_seq
   import div_pkg::*;
#(
   parameter int APPROX_BITS = 0,
   parameter int AW          = C_AW,
   parameter int BW          = C_BW
) (
   input  wire logic     clk,
   input  wire logic     rst,
   div_16x8_seq_if.slave bus
);

   // Last bit index processed; the RUN state ends after this iteration.
   localparam logic [3:0] C_K = 4'(APPROX_BITS);

   state_t          state_q, state_d;
   logic [3:0]      cnt_q,   cnt_d;
   logic [AW-1:0]   a_q,     a_d;
   logic [BW-1:0]   b_q,     b_d;
   logic [BW-1:0]   rem_q,   rem_d;
   logic [AW-1:0]   qacc_q,  qacc_d;
   logic [AW-1:0]   qout_q,  qout_d;
   logic [BW-1:0]   rout_q,  rout_d;
   logic            dz_q,    dz_d;

   logic [BW-1:0]   w_rem_nxt;
   logic            w_qbit;

   div_step u_step (
      .rem_i (rem_q),
      .bit_i (a_q[cnt_q]),
      .b_i   (b_q),
      .rem_o (w_rem_nxt),
      .q_o   (w_qbit)
   );

   //------------------------------------------------------------------
   // FSM state register
   //------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   //------------------------------------------------------------------
   // FSM next state
   //------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = (bus.B == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q == C_K) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   //------------------------------------------------------------------
   // Datapath next state
   //------------------------------------------------------------------
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      rem_d  = rem_q;
      qacc_d = qacc_q;
      qout_d = qout_q;
      rout_d = rout_q;
      dz_d   = dz_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d = bus.A;
               b_d = bus.B;
               if (bus.B == '0) begin
                  // Divide by zero: results are published straight away.
                  qout_d = C_DZ_QUOT;
                  rout_d = bus.A[BW-1:0];
                  dz_d   = 1'b1;
               end else begin
                  cnt_d  = 4'd15;
                  rem_d  = '0;
                  qacc_d = '0;
                  dz_d   = 1'b0;
               end
            end
         end
         ST_RUN: begin
            rem_d          = w_rem_nxt;
            qacc_d[cnt_q]  = w_qbit;
            cnt_d          = cnt_q - 4'd1;
            if (cnt_q == C_K) begin
               // Results land on the edge into DONE so they are valid while
               // done is high; skipped low bits stay zero from the clear.
               qout_d = qacc_d;
               rout_d = w_rem_nxt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rem_q  <= '0;
         qacc_q <= '0;
         qout_q <= '0;
         rout_q <= '0;
         dz_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         rem_q  <= rem_d;
         qacc_q <= qacc_d;
         qout_q <= qout_d;
         rout_q <= rout_d;
         dz_q   <= dz_d;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);
   assign bus.Q    = qout_q;
   assign bus.Rem  = rout_q;
   assign bus.DZ   = dz_q;

endmodule : div_16x8_seq
`default_nettype wire

// File: tb/tb_div_16x8_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_div_16x8_seq
// Description : Scoreboard testbench for div_16x8_seq. Two instances are
//               used: k=0 (exact) and k=4 (approximate). The driver pushes
//               hand-computed results together with the cycle the done pulse
//               is due; per-instance monitors compare on every done pulse.
// Revision    : 1.0 - initial release
//============================================================================
module tb_div_16x8_seq;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      int          acc;
      int          dn;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   exp_t sb0[$];
   exp_t sb4[$];

   div_16x8_seq_if bus0 ();
   div_16x8_seq_if bus4 ();

   div_16x8_seq #(.APPROX_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   div_16x8_seq #(.APPROX_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitors: compare on each done pulse, and keep busy/done honest between.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus0.done) begin
            if (sb0.size() == 0) begin
               chk("k0 unexpected done", 32'(bus0.done), 32'd0);
            end else begin
               exp_t e;
               e = sb0.pop_front();
               chk("k0 Q",   32'(bus0.Q),   32'(e.q));
               chk("k0 Rem", 32'(bus0.Rem), 32'(e.r));
               chk("k0 DZ",  32'(bus0.DZ),  32'(e.dz));
               chk("k0 latency", 32'(cyc), 32'(e.dn));
               chk("k0 busy at done", 32'(bus0.busy), 32'd0);
            end
         end else if (sb0.size() != 0) begin
            chk("k0 busy", 32'(bus0.busy), 32'((cyc > sb0[0].acc) && (cyc < sb0[0].dn)));
         end else begin
            chk("k0 busy idle", 32'(bus0.busy), 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus4.done) begin
            if (sb4.size() == 0) begin
               chk("k4 unexpected done", 32'(bus4.done), 32'd0);
            end else begin
               exp_t e;
               e = sb4.pop_front();
               chk("k4 Q",   32'(bus4.Q),   32'(e.q));
               chk("k4 Rem", 32'(bus4.Rem), 32'(e.r));
               chk("k4 DZ",  32'(bus4.DZ),  32'(e.dz));
               chk("k4 latency", 32'(cyc), 32'(e.dn));
            end
         end
      end
   end

   // Drive one request; the start cycle is the cycle in which start is high.
   task automatic issue(input int sel, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] q, input logic [7:0] r, input logic dz);
      exp_t e;
      @(posedge clk); #2;
      e.q = q; e.r = r; e.dz = dz; e.acc = cyc;
      if (sel == 0) begin
         e.dn = cyc + ((b == 8'd0) ? 1 : 17);
         bus0.start = 1'b1; bus0.A = a; bus0.B = b;
         sb0.push_back(e);
      end else begin
         e.dn = cyc + ((b == 8'd0) ? 1 : 13);
         bus4.start = 1'b1; bus4.A = a; bus4.B = b;
         sb4.push_back(e);
      end
      @(posedge clk); #2;
      bus0.start = 1'b0;
      bus4.start = 1'b0;
   endtask

   task automatic wait_empty(input int sel);
      int n;
      for (n = 0; n < 40; n++) begin
         if (((sel == 0) ? sb0.size() : sb4.size()) == 0) break;
         @(posedge clk); #2;
      end
      if (((sel == 0) ? sb0.size() : sb4.size()) != 0) begin
         chk("done timeout", 32'(n), 32'd0);
         if (sel == 0) sb0.delete(); else sb4.delete();
      end
   endtask

   initial begin
      bus0.start = 1'b0; bus0.A = '0; bus0.B = '0;
      bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset Q",    32'(bus0.Q),    32'd0);
      chk("reset Rem",  32'(bus0.Rem),  32'd0);
      chk("reset DZ",   32'(bus0.DZ),   32'd0);
      chk("reset busy", 32'(bus0.busy), 32'd0);
      chk("reset done", 32'(bus0.done), 32'd0);
      rst = 1'b0;

      // Exact divider
      issue(0, 16'd1000,  8'd7,   16'd142,   8'd6,    1'b0); wait_empty(0);
      issue(0, 16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0); wait_empty(0);
      issue(0, 16'd255,   8'd255, 16'd1,     8'd0,    1'b0); wait_empty(0);
      issue(0, 16'd5,     8'd200, 16'd0,     8'd5,    1'b0); wait_empty(0);
      issue(0, 16'h12AB,  8'd0,   16'hFFFF,  8'hAB,   1'b1); wait_empty(0);
      issue(0, 16'd10,    8'd3,   16'd3,     8'd1,    1'b0); wait_empty(0);

      // Approximate divider, k=4
      issue(4, 16'd1000,  8'd7,   16'd128,   8'd6,    1'b0); wait_empty(4);
      issue(4, 16'd65535, 8'd1,   16'hFFF0,  8'd0,    1'b0); wait_empty(4);
      issue(4, 16'h3456,  8'd0,   16'hFFFF,  8'h56,   1'b1); wait_empty(4);

      // start held through RUN and the done cycle with changing operands
      begin
         exp_t e;
         @(posedge clk); #2;
         e.q = 16'd142; e.r = 8'd6; e.dz = 1'b0; e.acc = cyc; e.dn = cyc + 17;
         bus0.start = 1'b1; bus0.A = 16'd1000; bus0.B = 8'd7;
         sb0.push_back(e);
         for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #2;
            bus0.A = 16'(i * 977);
            bus0.B = 8'((i % 3 == 0) ? 0 : i + 2);
         end
         @(posedge clk); #2;
         bus0.start = 1'b0;
         wait_empty(0);
         repeat (20) @(posedge clk);
      end

      // Reset during iteration 8
      @(posedge clk); #2;
      begin
         exp_t e;
         e.q = 16'd142; e.r = 8'd6; e.dz = 1'b0; e.acc = cyc; e.dn = cyc + 17;
         bus0.start = 1'b1; bus0.A = 16'd1000; bus0.B = 8'd7;
         sb0.push_back(e);
      end
      @(posedge clk); #2;
      bus0.start = 1'b0;
      repeat (7) begin @(posedge clk); #2; end
      chk("busy before rst", 32'(bus0.busy), 32'd1);
      rst = 1'b1;
      sb0.delete();
      #1;
      chk("rst Q",    32'(bus0.Q),    32'd0);
      chk("rst Rem",  32'(bus0.Rem),  32'd0);
      chk("rst DZ",   32'(bus0.DZ),   32'd0);
      chk("rst busy", 32'(bus0.busy), 32'd0);
      chk("rst done", 32'(bus0.done), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      issue(0, 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0); wait_empty(0);

      repeat (5) @(posedge clk);
      chk("k0 queue empty", 32'(sb0.size()), 32'd0);
      chk("k4 queue empty", 32'(sb4.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1);
   end

endmodule : tb_div_16x8_seq
`default_nettype wire
